// File: rtl/trace_checker.sv
// trace_checker: compares CPU write-back trace against a golden ROM stream.
// A 2-entry prefetch FIFO (with in-flight bypass) feeds the in-order comparator.
module trace_checker #(
    parameter int TRACE_LEN = 1024,
    parameter int AW = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          debug_wb_have_inst,
    input  logic [31:0]   debug_wb_pc,
    input  logic          debug_wb_ena,
    input  logic [4:0]    debug_wb_reg,
    input  logic [31:0]   debug_wb_value,
    output logic          gold_re,
    output logic [AW-1:0] gold_addr,
    input  logic [69:0]   gold_data,
    output logic          ready,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [2:0]    err_code,
    output logic [31:0]   inst_cnt,
    output logic [31:0]   err_pc,
    output logic [31:0]   err_exp,
    output logic [31:0]   err_act
);
    typedef enum logic [2:0] {IDLE, FILL, RUN, PASS, FAIL} state_t;
    localparam int NEED = TRACE_LEN < 2 ? TRACE_LEN : 2;

    state_t state, next;
    logic [69:0] mem0, mem1, head;
    logic [1:0] occ, slot;
    logic in_flight, empty, early, retire, ok, pop_f, push, wd_hit, g_eff, a_eff;
    logic [AW:0] rd_ptr;
    logic [31:0] wd;
    logic [2:0] code;

    // When the FIFO is empty the in-flight ROM word is compared directly, so
    // back-to-back retirements never starve.
    assign head = occ == 2'd0 ? gold_data : mem0;
    assign empty = occ == 2'd0 && !in_flight;
    assign retire = state == RUN && debug_wb_have_inst;
    assign early = debug_wb_have_inst && (state == IDLE || state == FILL || (state == RUN && empty));
    assign g_eff = head[69] && head[68:64] != 5'd0;
    assign a_eff = debug_wb_ena && debug_wb_reg != 5'd0;
    assign code = debug_wb_pc != head[63:32] ? 3'd1 :
                  (g_eff != a_eff || (g_eff && debug_wb_reg != head[68:64])) ? 3'd2 :
                  (g_eff && debug_wb_value != head[31:0]) ? 3'd3 : 3'd0;
    assign ok = retire && !empty && code == 3'd0;
    assign pop_f = ok && occ != 2'd0;
    assign push = in_flight && !(ok && occ == 2'd0);
    assign slot = occ - {1'b0, pop_f};
    assign wd_hit = state == RUN && !debug_wb_have_inst && wd == 32'(TIMEOUT - 1);
    assign gold_re = (state == FILL || state == RUN) && (occ + {1'b0, in_flight}) < 2'd2
                     && 32'(rd_ptr) < 32'(TRACE_LEN);
    assign gold_addr = rd_ptr[AW-1:0];

    always_comb begin
        next = state;
        if (state == IDLE)
            next = early ? FAIL : start ? (TRACE_LEN == 0 ? PASS : FILL) : IDLE;
        else if (state == FILL)
            next = early ? FAIL : 32'(occ) >= 32'(NEED) ? RUN : FILL;
        else if (state == RUN)
            next = (early || (retire && code != 3'd0) || wd_hit) ? FAIL :
                   (ok && inst_cnt + 32'd1 == 32'(TRACE_LEN)) ? PASS : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mem0 <= '0;
            mem1 <= '0;
            occ <= '0;
            in_flight <= 1'b0;
            rd_ptr <= '0;
            wd <= '0;
            ready <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            err_code <= '0;
            inst_cnt <= '0;
            err_pc <= '0;
            err_exp <= '0;
            err_act <= '0;
        end else begin
            state <= next;
            ready <= next == RUN;
            in_flight <= gold_re;
            if (gold_re) rd_ptr <= rd_ptr + 1'b1;
            if (pop_f) mem0 <= mem1;
            if (push && slot == 2'd0) mem0 <= gold_data;
            if (push && slot != 2'd0) mem1 <= gold_data;
            occ <= occ + {1'b0, push} - {1'b0, pop_f};
            wd <= (state == RUN && !debug_wb_have_inst) ? wd + 32'd1 : 32'd0;
            if (ok) inst_cnt <= inst_cnt + 32'd1;
            if (next == PASS && state != PASS) begin
                done <= 1'b1;
                pass <= 1'b1;
            end
            if (next == FAIL && state != FAIL) begin
                done <= 1'b1;
                fail <= 1'b1;
                err_code <= early ? 3'd5 : wd_hit ? 3'd4 : code;
                err_pc <= debug_wb_have_inst ? debug_wb_pc : 32'd0;
                err_act <= debug_wb_have_inst ? debug_wb_value : 32'd0;
                err_exp <= (early || wd_hit) ? 32'd0 : head[31:0];
            end
        end
    end
endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: directed checks of trace_checker with a small golden ROM model.
module tb_trace_checker;
    logic clk = 0, rst_n = 0, start = 0;
    logic have = 0, ena = 0;
    logic [4:0] rg = 0;
    logic [31:0] pc = 0, val = 0;
    logic gold_re, ready, done, pass, fail;
    logic [2:0] gold_addr, err_code;
    logic [69:0] gold_data = '0;
    logic [31:0] inst_cnt, err_pc, err_exp, err_act;
    logic g_ena [8];
    logic [4:0] g_reg [8];
    logic [31:0] g_pc [8], g_val [8];
    int compared = 0, mismatched = 0;

    trace_checker #(.TRACE_LEN(4), .AW(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .debug_wb_have_inst(have), .debug_wb_pc(pc), .debug_wb_ena(ena),
        .debug_wb_reg(rg), .debug_wb_value(val),
        .gold_re(gold_re), .gold_addr(gold_addr), .gold_data(gold_data),
        .ready(ready), .done(done), .pass(pass), .fail(fail), .err_code(err_code),
        .inst_cnt(inst_cnt), .err_pc(err_pc), .err_exp(err_exp), .err_act(err_act));

    always #5 clk = ~clk;
    always @(posedge clk) if (gold_re) gold_data <= {g_ena[gold_addr], g_reg[gold_addr], g_pc[gold_addr], g_val[gold_addr]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rom(input int i, input logic e, input logic [4:0] r, input logic [31:0] p, input logic [31:0] v);
        g_ena[i] = e; g_reg[i] = r; g_pc[i] = p; g_val[i] = v;
    endtask

    task automatic rom_std();
        set_rom(0, 1, 5'd1, 32'h0, 32'h11);
        set_rom(1, 0, 5'd0, 32'h4, 32'h0);
        set_rom(2, 1, 5'd3, 32'h8, 32'h33);
        set_rom(3, 1, 5'd0, 32'hC, 32'h0);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #2 rst_n = 1;
        tick();
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && !ready; i++) tick();
        chk("ready", ready, 1);
    endtask

    task automatic retire(input logic [31:0] p, input logic e, input logic [4:0] r, input logic [31:0] v);
        have = 1; pc = p; ena = e; rg = r; val = v;
        tick();
        have = 0;
    endtask

    task automatic play(input int gap);
        for (int i = 0; i < 4; i++) begin
            retire(g_pc[i], g_ena[i], g_reg[i], g_val[i]);
            for (int k = 0; k < gap + i % 3; k++) tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) set_rom(i, 0, 5'd0, 32'h0, 32'h0);
        rom_std();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_code", err_code, 0);
        chk("rst_cnt", inst_cnt, 0);
        chk("rst_re", gold_re, 0);
        rst_n = 1;
        tick();
        chk("idle_re", gold_re, 0);
        // T1: back-to-back matching retirements
        go();
        play(0);
        chk("t1_pass", pass, 1);
        chk("t1_done", done, 1);
        chk("t1_fail", fail, 0);
        chk("t1_cnt", inst_cnt, 4);
        chk("t1_ready", ready, 0);
        retire(32'h40, 1, 5'd9, 32'h9);
        chk("t1_hold_fail", fail, 0);
        chk("t1_hold_cnt", inst_cnt, 4);
        // T2: PC mismatch on 3rd retirement
        do_reset();
        set_rom(2, 1, 5'd3, 32'hC, 32'h33);
        go();
        retire(g_pc[0], g_ena[0], g_reg[0], g_val[0]);
        retire(g_pc[1], g_ena[1], g_reg[1], g_val[1]);
        retire(32'h8, 1, 5'd3, 32'h33);
        chk("t2_fail", fail, 1);
        chk("t2_pass", pass, 0);
        chk("t2_code", err_code, 1);
        chk("t2_pc", err_pc, 32'h8);
        chk("t2_exp", err_exp, 32'h33);
        chk("t2_cnt", inst_cnt, 2);
        retire(32'h100, 1, 5'd1, 32'h1);
        chk("t2_hold_pc", err_pc, 32'h8);
        // T3: reg=0 vs gold ena=0 matches, then a value mismatch
        do_reset();
        set_rom(0, 0, 5'd7, 32'h0, 32'h5);
        set_rom(1, 1, 5'd5, 32'h4, 32'h10);
        go();
        retire(32'h0, 1, 5'd0, 32'h99);
        chk("t3_cnt1", inst_cnt, 1);
        chk("t3_nofail", fail, 0);
        retire(32'h4, 1, 5'd5, 32'h11);
        chk("t3_code", err_code, 3);
        chk("t3_exp", err_exp, 32'h10);
        chk("t3_act", err_act, 32'h11);
        chk("t3_cnt", inst_cnt, 1);
        // T3b: destination register mismatch
        do_reset();
        go();
        retire(32'h0, 1, 5'd0, 32'h0);
        retire(32'h4, 1, 5'd6, 32'h10);
        chk("t3b_code", err_code, 2);
        // T4: watchdog
        do_reset();
        rom_std();
        go();
        for (int i = 0; i < 14; i++) tick();
        chk("t4_early", fail, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_fail", fail, 1);
        chk("t4_code", err_code, 4);
        chk("t4_exp", err_exp, 0);
        // T5: retirement during FILL, then gapped retirements
        do_reset();
        start = 1;
        tick();
        start = 0;
        retire(32'h0, 1, 5'd1, 32'h11);
        chk("t5_fail", fail, 1);
        chk("t5_code", err_code, 5);
        chk("t5_exp", err_exp, 0);
        chk("t5_act", err_act, 32'h11);
        do_reset();
        go();
        play(1);
        chk("t5_gap_pass", pass, 1);
        chk("t5_gap_cnt", inst_cnt, 4);
        chk("t5_gap_fail", fail, 0);
        // T6: asynchronous reset mid-RUN, then restart
        do_reset();
        go();
        retire(g_pc[0], g_ena[0], g_reg[0], g_val[0]);
        retire(g_pc[1], g_ena[1], g_reg[1], g_val[1]);
        chk("t6_mid_cnt", inst_cnt, 2);
        #2 rst_n = 0;
        #1;
        chk("t6_ready", ready, 0);
        chk("t6_cnt", inst_cnt, 0);
        chk("t6_done", done, 0);
        tick();
        rst_n = 1;
        tick();
        start = 1;
        tick();
        start = 0;
        chk("t6_re", gold_re, 1);
        chk("t6_addr", gold_addr, 0);
        for (int i = 0; i < 20 && !ready; i++) tick();
        chk("t6_ready2", ready, 1);
        play(0);
        chk("t6_pass", pass, 1);
        chk("t6_cnt4", inst_cnt, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
